// File: rtl/uart_word_tx.sv
// rtl/uart_word_tx.sv - word-wide UART transmitter, MSB byte first, 8N1 frames
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits of each frame.
module uart_word_tx #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8,
  parameter int N_TICKS = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_valid,
  input  logic               i_tick,
  output logic               o_ready,
  output logic               o_data
);

  localparam int NB_WORDS = NB_DATA / NB_BYTE;
  localparam int TICK_W   = (N_TICKS > 1) ? $clog2(N_TICKS) : 1;
  localparam int BIT_W    = (NB_BYTE > 1) ? $clog2(NB_BYTE) : 1;
  localparam int BYTE_W   = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;

  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(N_TICKS - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(NB_BYTE - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NB_WORDS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t              state, state_n;
  logic [NB_DATA-1:0]  shift_reg, shift_n;
  logic [TICK_W-1:0]   tick_cnt, tick_n;
  logic [BIT_W-1:0]    bit_cnt, bit_n;
  logic [BYTE_W-1:0]   byte_cnt, byte_n;
  logic [NB_BYTE-1:0]  next_byte;
  logic                bit_end;
  logic                data_n;
  logic                ready_n;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      o_data    <= 1'b1;
      o_ready   <= 1'b1;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      tick_cnt  <= tick_n;
      bit_cnt   <= bit_n;
      byte_cnt  <= byte_n;
      o_data    <= data_n;
      o_ready   <= ready_n;
    end
  end

  always_comb begin
    state_n = state;
    shift_n = shift_reg;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    byte_n  = byte_cnt;
    bit_end = i_tick && (tick_cnt == LAST_TICK);

    if (state != S_IDLE && i_tick) begin
      tick_n = bit_end ? '0 : tick_cnt + 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (i_valid) begin
          state_n = S_START;
          shift_n = i_data;
          tick_n  = '0;
          bit_n   = '0;
          byte_n  = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          bit_n   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt == LAST_BIT) begin
            bit_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_n = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (byte_cnt == LAST_BYTE) begin
            state_n = S_IDLE;
          end else begin
            // next frame starts immediately: no idle gap between bytes
            shift_n = shift_reg << NB_BYTE;
            byte_n  = byte_cnt + 1'b1;
            state_n = S_START;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // outputs are computed from next state so the line comes straight off a flop
    next_byte = shift_n[NB_DATA-1 -: NB_BYTE];
    case (state_n)
      S_IDLE:   data_n = 1'b1;
      S_START:  data_n = 1'b0;
      S_DATA:   data_n = next_byte[bit_n];
`ifdef UART_TX_PARITY_EN
      S_PARITY: data_n = ^next_byte;
`endif
      S_STOP:   data_n = 1'b1;
      default:  data_n = 1'b1;
    endcase
    ready_n = (state_n == S_IDLE);
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// tb/tb_uart_word_tx.sv - randomized bench for uart_word_tx against a tick-count line model
module tb_uart_word_tx;

  localparam int NB_DATA = 32;
  localparam int N_TICKS = 16;
  localparam int NW      = NB_DATA / 8;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int TOTAL = FB * N_TICKS * NW;
  localparam int LIMIT = TOTAL * 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data;
  logic        valid;
  logic        tick;
  logic        ready;
  logic        line;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;
  bit tick_on = 0;

  // reference model: a busy word is just its value and the ticks elapsed since acceptance
  bit          m_busy = 0;
  int          m_elapsed = 0;
  logic [31:0] m_word = '0;
  int          m_accepts = 0;
  int          busy_total = 0;

  uart_word_tx #(.NB_DATA(NB_DATA), .NB_BYTE(8), .N_TICKS(N_TICKS)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_data  (data),
    .i_valid (valid),
    .i_tick  (tick),
    .o_ready (ready),
    .o_data  (line)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic line_bit(input logic [31:0] w, input int el);
    int bp  = el / N_TICKS;
    int fr  = bp / FB;
    int pos = bp % FB;
    logic [7:0] b;
    b = 8'((w >> (8 * (NW - 1 - fr))) & 32'hFF);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (FB == 11 && pos == 9) return ^b;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (!ready && tick) busy_total <= busy_total + 1;
    if (reset) begin
      m_busy    <= 0;
      m_elapsed <= 0;
    end else if (m_busy) begin
      if (tick) begin
        m_elapsed <= m_elapsed + 1;
        if (m_elapsed + 1 == TOTAL) m_busy <= 0;
      end
    end else if (valid) begin
      m_busy    <= 1;
      m_word    <= data;
      m_elapsed <= 0;
      m_accepts <= m_accepts + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("ready", 32'(ready), 32'(!m_busy));
      check("line", 32'(line), m_busy ? 32'(line_bit(m_word, m_elapsed)) : 32'd1);
    end
  end

  initial begin
    int gap = 0;
    tick = 0;
    forever begin
      @(negedge clk);
      if (tick_on && gap == 0) begin
        tick = 1;
        gap = $urandom_range(1, 3);
      end else begin
        tick = 0;
        if (gap > 0) gap--;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (m_busy && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(m_busy), 32'd0);
  endtask

  task automatic wait_elapsed(input int target);
    int n = 0;
    while (m_busy && m_elapsed < target && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("elapsed_timeout", 32'(n >= LIMIT), 32'd0);
  endtask

  task automatic send(input logic [31:0] w);
    wait_idle();
    @(negedge clk);
    data  = w;
    valid = 1;
    @(negedge clk);
    valid = 0;
  endtask

  task automatic run_word(input logic [31:0] w);
    int snap;
    wait_idle();
    snap = busy_total;
    send(w);
    wait_idle();
    @(negedge clk);
    check("busy_ticks", 32'(busy_total - snap), 32'(TOTAL));
  endtask

  initial begin
    int base;
    reset = 1;
    valid = 0;
    data  = '0;
    tick_on = 1;
    @(posedge clk);
    #1 chk_on = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (200) @(negedge clk);

    run_word(32'h41424344);

    // back-to-back with valid held: second word taken on the first ready cycle
    wait_idle();
    base = m_accepts;
    @(negedge clk);
    data  = 32'hDEADBEEF;
    valid = 1;
    for (int n = 0; n < LIMIT && m_accepts == base; n++) @(negedge clk);
    data = 32'h00000001;
    for (int n = 0; n < LIMIT && m_accepts < base + 2; n++) @(negedge clk);
    valid = 0;
    check("b2b_accepts", 32'(m_accepts - base), 32'd2);
    wait_idle();

    // valid while busy is ignored
    send(32'h12345678);
    wait_elapsed(FB * N_TICKS + 3 * N_TICKS);
    data  = 32'hFFFFFFFF;
    valid = 1;
    @(negedge clk);
    valid = 0;
    wait_idle();
    repeat (100) @(negedge clk);

    // reset during data bits of the third byte
    send(32'hA5A5A5A5);
    wait_elapsed(2 * FB * N_TICKS + 3 * N_TICKS);
    reset = 1;
    @(negedge clk);
    reset = 0;
    run_word(32'h01020304);

`ifdef UART_TX_PARITY_EN
    run_word(32'h07000000);
`endif

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      send($urandom);
      wait_elapsed($urandom_range(0, TOTAL - 1));
      if (m_busy) begin
        data  = $urandom;
        valid = 1;
        @(negedge clk);
        valid = 0;
      end
      wait_idle();
    end

    tick_on = 0;
    repeat (50) @(negedge clk);
    tick_on = 1;
    repeat (50) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Word-oriented UART transmitter that sits directly downstream of the debug unit. It accepts one NB_DATA-bit word per valid/ready handshake and serializes it as NB_DATA/8 consecutive 8N1 UART frames, most significant byte first, on the FPGA TX pin. Bit timing is driven by the shared baud-rate generator's oversampling tick. It carries PC, register and data-memory dumps back to the host.

## Interface

Parameters:
- NB_DATA, 32, width of accepted word; must be a multiple of NB_BYTE.
- NB_BYTE, 8, data bits per UART frame.
- N_TICKS, 16, i_tick pulses per UART bit period.

Ports:
- i_clk, input, 1, system clock.
- i_reset, input, 1, reset; synchronous, active-high.
- i_data, input, NB_DATA, word to send; sampled on handshake.
- i_valid, input, 1, word-valid strobe; single-cycle pulse is sufficient.
- i_tick, input, 1, oversampling tick from the baud generator; one i_clk cycle wide.
- o_ready, output, 1, high when idle and able to accept a word.
- o_data, output, 1, serial TX line; idle level 1.

## Operation

- Handshake: a word is accepted on any rising edge where o_ready && i_valid. i_data is latched into a NB_DATA-bit shift register. i_valid while o_ready=0 is ignored; there is no queueing and no error flag.
- FSM states: IDLE, START, DATA, STOP, plus PARITY when UART_TX_PARITY_EN is defined.
  - IDLE: o_data=1, o_ready=1. On handshake, go to START, clear tick_cnt, bit_cnt and byte_cnt.
  - START: o_data=0.
  - DATA: o_data = current byte LSB-first. Bit k of the byte is shift_reg[NB_DATA-NB_BYTE+k].
  - STOP: o_data=1.
- tick_cnt (log2 N_TICKS bits) increments on each i_tick. When tick_cnt==N_TICKS-1 and i_tick=1, the current bit period ends and tick_cnt wraps to 0.
- End of START: go to DATA with bit_cnt=0.
- End of each DATA bit: bit_cnt increments. After bit NB_BYTE-1, go to STOP (or PARITY).
- End of STOP:
  - If byte_cnt != NB_DATA/NB_BYTE-1: shift register shifts left by NB_BYTE, byte_cnt increments, go to START. There is no idle gap between frames.
  - Otherwise go to IDLE.
- Frame cost: (NB_BYTE+2)*N_TICKS ticks; one word costs NB_DATA/NB_BYTE frames (640 ticks with defaults).
- Reset mid-word: the word is discarded. Next edge: state IDLE, o_data=1, o_ready=1, all counters 0.

## Timing

- Reset values: o_data=1, o_ready=1, shift register 0, tick_cnt=0, bit_cnt=0, byte_cnt=0.
- o_data and o_ready are registered (driven from state and shift register flops), so the line is glitch-free.
- Handshake at edge N: o_ready=0 and o_data=0 (start bit) from cycle N+1.
- The start bit lasts exactly N_TICKS i_tick pulses counted from cycle N+1. A tick coincident with the handshake cycle is not counted.
- The last stop bit ends on the N_TICKS-th tick of that bit. o_ready=1 from the following cycle, and a new handshake is legal in that same cycle. Back-to-back words therefore have a stop-bit-to-start-bit spacing identical to inter-byte spacing.
- i_tick has no effect in IDLE.
- Latency from handshake to first start-bit edge on o_data: 1 cycle.

## Configuration

- UART_TX_PARITY_EN defined:
  - A PARITY state is inserted between DATA and STOP, lasting N_TICKS ticks.
  - o_data = even parity (XOR) of the 8 data bits of the current byte.
  - Frame becomes 11 bits; one word costs 704 ticks with defaults.
- UART_TX_PARITY_EN undefined: 8N1, no PARITY state, no parity logic synthesized.
- The host-side receiver must match the configuration.

## Test plan

- Reset: hold i_reset 3 cycles with i_tick running -> o_data=1 and o_ready=1 throughout and afterwards; no activity without i_valid.
- Single word: i_data=0x41424344, one-cycle i_valid -> bytes 0x41, 0x42, 0x43, 0x44 decoded in order, each 0,LSB-first data,1. Each bit lasts exactly 16 ticks. o_ready=0 for exactly 640 ticks, then returns to 1.
- Back-to-back: drive 0xDEADBEEF then 0x00000001 with i_valid held high -> second handshake occurs in the first cycle o_ready=1. Eight frames with no idle gap: DE AD BE EF 00 00 00 01.
- Busy ignore: pulse i_valid with i_data=0xFFFFFFFF during the second byte of 0x12345678 -> line carries only 12 34 56 78; no extra frames follow.
- Reset mid-word: assert i_reset during DATA of the 3rd byte of 0xA5A5A5A5 -> next cycle o_data=1, o_ready=1. A subsequent word 0x01020304 is sent cleanly.
- Parity build (UART_TX_PARITY_EN): send 0x07000000 -> parity bits 1,0,0,0 for bytes 07,00,00,00. Each frame is 11 bit periods; o_ready is low for 704 ticks.
